// File: rtl/cd_responder.sv
// cd_responder: CD-drive side of the SCSI<->CD bridge.
// Accepts a 12-byte CDB, runs TEST UNIT READY / READ(10) against a byte-wide
// sector source, streams read data back to the bridge and reports status.
// Every output is a register, so reset drives all of them to 0 at once.
module cd_responder #(
  parameter int BYTE_GAP   = 4,     // min cycles between CD_WR pulses (>=1)
  parameter int SECT_BYTES = 2048   // bytes per logical block
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [95:0] COMMAND,
  input  logic        COMM_SEND,
  output logic [7:0]  STATUS,
  output logic        STAT_GET,
  output logic [7:0]  CD_DATA,
  output logic        CD_WR,
  output logic        CD_DATA_END,
  output logic [31:0] SRC_LBA,
  output logic        SRC_RD,
  input  logic [7:0]  SRC_DATA,
  input  logic        SRC_VALID,
  output logic        BUSY
);

  localparam int GW = $clog2(BYTE_GAP + 1);
  localparam int BW = (SECT_BYTES > 1) ? $clog2(SECT_BYTES) : 1;

  localparam logic [GW-1:0] GAP_SAT      = GW'(BYTE_GAP);
  localparam logic [BW-1:0] BLK_LAST     = BW'(SECT_BYTES - 1);
  localparam logic [26:0]   SECT_BYTES_W = 27'(SECT_BYTES);

  localparam logic [7:0] OP_TUR    = 8'h00;
  localparam logic [7:0] OP_READ10 = 8'h28;
  localparam logic [7:0] ST_GOOD   = 8'h00;
  localparam logic [7:0] ST_CHECK  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_PUSH,
    S_END,
    S_STAT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [31:0]   lba_q, lba_d;
  logic [15:0]   blocks_q, blocks_d;
  logic [26:0]   remaining_q, remaining_d;
  logic [BW-1:0] byte_in_blk_q, byte_in_blk_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    byte_buf_q, byte_buf_d;

  logic [7:0]    status_q, status_d;
  logic          stat_get_q, stat_get_d;
  logic [7:0]    cd_data_q, cd_data_d;
  logic          cd_wr_q, cd_wr_d;
  logic          cd_end_q, cd_end_d;
  logic [31:0]   src_lba_q, src_lba_d;
  logic          src_rd_q, src_rd_d;
  logic          busy_q, busy_d;

  // Only opcode, LBA and transfer length matter; the remaining CDB bytes are
  // reserved/control fields this drive ignores.
  logic unused_cdb_bytes;
  assign unused_cdb_bytes = ^{COMMAND[15:8], COMMAND[55:48], COMMAND[95:72]};

  // Next-state and output decode for the command FSM.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    opcode_d      = opcode_q;
    lba_d         = lba_q;
    blocks_d      = blocks_q;
    remaining_d   = remaining_q;
    byte_in_blk_d = byte_in_blk_q;
    byte_buf_d    = byte_buf_q;
    status_d      = status_q;
    cd_data_d     = cd_data_q;
    src_lba_d     = src_lba_q;
    stat_get_d    = 1'b0;
    cd_wr_d       = 1'b0;
    cd_end_d      = 1'b0;
    src_rd_d      = 1'b0;
    // Gap counter counts up and saturates; it is re-armed by each CD_WR.
    gap_d         = (gap_q == GAP_SAT) ? gap_q : gap_q + GW'(1);

    unique case (state_q)
      S_IDLE: begin
        // busy_q is still high during the STAT_GET cycle, so a strobe there is dropped.
        if (COMM_SEND && !busy_q) begin
          opcode_d = COMMAND[7:0];
          lba_d    = {COMMAND[23:16], COMMAND[31:24], COMMAND[39:32], COMMAND[47:40]};
          blocks_d = {COMMAND[63:56], COMMAND[71:64]};
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (opcode_q == OP_READ10) begin
          if (blocks_q == 16'd0) begin
            status_d = ST_GOOD;
            state_d  = S_STAT;
          end else begin
            remaining_d   = {11'd0, blocks_q} * SECT_BYTES_W;
            byte_in_blk_d = '0;
            src_lba_d     = lba_q;
            src_rd_d      = 1'b1;
            state_d       = S_FETCH;
          end
        end else if (opcode_q == OP_TUR) begin
          status_d = ST_GOOD;
          state_d  = S_STAT;
        end else begin
          status_d = ST_CHECK;
          state_d  = S_STAT;
        end
      end

      S_FETCH: begin
        if (SRC_VALID) begin
          byte_buf_d = SRC_DATA;
          state_d    = S_PUSH;
        end
      end

      S_PUSH: begin
        if (gap_q >= GAP_SAT) begin
          cd_wr_d     = 1'b1;
          cd_data_d   = byte_buf_q;
          gap_d       = GW'(1);
          remaining_d = remaining_q - 27'd1;
          if (byte_in_blk_q == BLK_LAST) begin
            byte_in_blk_d = '0;
            src_lba_d     = src_lba_q + 32'd1;
          end else begin
            byte_in_blk_d = byte_in_blk_q + BW'(1);
          end
          if (remaining_q == 27'd1) begin
            state_d = S_END;
          end else begin
            src_rd_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end

      S_END: begin
        cd_end_d = 1'b1;
        status_d = ST_GOOD;
        state_d  = S_STAT;
      end

      S_STAT: begin
        stat_get_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // BUSY covers the whole command including the STAT_GET cycle itself.
    busy_d = (state_d != S_IDLE) || stat_get_d;
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q       <= S_IDLE;
      opcode_q      <= '0;
      lba_q         <= '0;
      blocks_q      <= '0;
      remaining_q   <= '0;
      byte_in_blk_q <= '0;
      gap_q         <= GAP_SAT;
      byte_buf_q    <= '0;
      status_q      <= '0;
      stat_get_q    <= 1'b0;
      cd_data_q     <= '0;
      cd_wr_q       <= 1'b0;
      cd_end_q      <= 1'b0;
      src_lba_q     <= '0;
      src_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      lba_q         <= lba_d;
      blocks_q      <= blocks_d;
      remaining_q   <= remaining_d;
      byte_in_blk_q <= byte_in_blk_d;
      gap_q         <= gap_d;
      byte_buf_q    <= byte_buf_d;
      status_q      <= status_d;
      stat_get_q    <= stat_get_d;
      cd_data_q     <= cd_data_d;
      cd_wr_q       <= cd_wr_d;
      cd_end_q      <= cd_end_d;
      src_lba_q     <= src_lba_d;
      src_rd_q      <= src_rd_d;
      busy_q        <= busy_d;
    end
  end

  assign STATUS      = status_q;
  assign STAT_GET    = stat_get_q;
  assign CD_DATA     = cd_data_q;
  assign CD_WR       = cd_wr_q;
  assign CD_DATA_END = cd_end_q;
  assign SRC_LBA     = src_lba_q;
  assign SRC_RD      = src_rd_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_cd_responder.sv
// tb_cd_responder: scoreboard bench for cd_responder.
// Stimulus pushes expected CD_WR / CD_DATA_END / STAT_GET events into a queue;
// a negedge monitor pops and compares whenever the DUT pulses one of them.
module tb_cd_responder;

  localparam int GAP  = 4;
  localparam int SECT = 2048;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_END  = 2'd1;
  localparam logic [1:0] K_STAT = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] command;
  logic        comm_send;
  logic [7:0]  status;
  logic        stat_get;
  logic [7:0]  cd_data;
  logic        cd_wr;
  logic        cd_end;
  logic [31:0] src_lba;
  logic        src_rd;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Monitor-owned counters
  int wr_cnt = 0, end_cnt = 0, stat_cnt = 0, rd_cnt = 0, busy_cnt = 0;
  int stat_cyc = 0;
  int last_wr  = -1000;

  // Stimulus-owned
  int          cmd_cyc   = 0;
  logic [31:0] src_start = '0;
  int          lat_mode  = 0;

  exp_t exp_q[$];

  cd_responder #(.BYTE_GAP(GAP), .SECT_BYTES(SECT)) dut (
    .CLK        (clk),
    .RES        (rst),
    .COMMAND    (command),
    .COMM_SEND  (comm_send),
    .STATUS     (status),
    .STAT_GET   (stat_get),
    .CD_DATA    (cd_data),
    .CD_WR      (cd_wr),
    .CD_DATA_END(cd_end),
    .SRC_LBA    (src_lba),
    .SRC_RD     (src_rd),
    .SRC_DATA   (src_data),
    .SRC_VALID  (src_valid),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [7:0] val,
                         input bit cmp_val, input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({nm, "_unexpected"}, 64'(kind) + 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, 64'(kind), 64'(e.kind));
      if (cmp_val) check({nm, "_val"}, 64'(val), 64'(e.val));
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge.
  initial begin
    forever begin
      int n;
      @(negedge clk);
      n = int'(cd_wr) + int'(cd_end) + int'(stat_get);
      if (n > 0) check("pulse_exclusive", 64'(n), 64'd1);
      if (busy)   busy_cnt++;
      if (src_rd) rd_cnt++;
      if (cd_wr) begin
        wr_cnt++;
        if (cyc - last_wr < GAP) begin
          checks++;
          failures++;
          $display("FAIL wr_spacing: got %0d cycles required >= %0d", cyc - last_wr, GAP);
        end else begin
          checks++;
        end
        last_wr = cyc;
        pop_cmp(K_WR, cd_data, 1'b1, "cd_wr");
      end
      if (cd_end) begin
        end_cnt++;
        pop_cmp(K_END, 8'h00, 1'b0, "cd_end");
      end
      if (stat_get) begin
        stat_cnt++;
        stat_cyc = cyc;
        pop_cmp(K_STAT, status, 1'b1, "stat_get");
      end
    end
  end

  // Sector source: answers each SRC_RD after a configurable latency with
  // byte = SRC_LBA[7:0] ^ byte index within the transfer.
  initial begin
    int          src_idx;
    int          lat;
    logic [7:0]  d;
    logic [31:0] exp_lba;
    src_valid = 1'b0;
    src_data  = 8'h00;
    src_idx   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) src_idx = 0;
      if (src_rd) begin
        exp_lba = src_start + 32'(src_idx / SECT);
        check("src_lba", 64'(src_lba), 64'(exp_lba));
        d = src_lba[7:0] ^ src_idx[7:0];
        src_idx++;
        case (lat_mode)
          1:       lat = int'($urandom_range(0, 20));
          2:       lat = 6;
          default: lat = 2;
        endcase
        repeat (lat) @(posedge clk);
        if (lat > 0) #1;
        src_data  = d;
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
      end
    end
  end

  function automatic logic [95:0] cdb_read(input logic [31:0] lba, input logic [15:0] len);
    logic [95:0] c;
    c         = '0;
    c[7:0]    = 8'h28;
    c[23:16]  = lba[31:24];
    c[31:24]  = lba[23:16];
    c[39:32]  = lba[15:8];
    c[47:40]  = lba[7:0];
    c[63:56]  = len[15:8];
    c[71:64]  = len[7:0];
    return c;
  endfunction

  function automatic logic [95:0] cdb_op(input logic [7:0] op);
    logic [95:0] c;
    c      = '0;
    c[7:0] = op;
    return c;
  endfunction

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_bytes(input logic [31:0] lba, input int nbytes);
    logic [31:0] l;
    logic [7:0]  idx8;
    for (int i = 0; i < nbytes; i++) begin
      l    = lba + 32'(i / SECT);
      idx8 = 8'(i);
      push_ev(K_WR, l[7:0] ^ idx8);
    end
  endtask

  task automatic send(input logic [95:0] cmd);
    @(negedge clk);
    command   = cmd;
    comm_send = 1'b1;
    cmd_cyc   = cyc;
    @(negedge clk);
    comm_send = 1'b0;
  endtask

  task automatic wait_stat(input int s0, input int budget);
    int n;
    n = 0;
    while (stat_cnt == s0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("stat_get_seen", 64'(stat_cnt - s0), 64'd1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_status"},   64'(status),   64'd0);
    check({pfx, "_stat_get"}, 64'(stat_get), 64'd0);
    check({pfx, "_cd_data"},  64'(cd_data),  64'd0);
    check({pfx, "_cd_wr"},    64'(cd_wr),    64'd0);
    check({pfx, "_cd_end"},   64'(cd_end),   64'd0);
    check({pfx, "_src_lba"},  64'(src_lba),  64'd0);
    check({pfx, "_src_rd"},   64'(src_rd),   64'd0);
    check({pfx, "_busy"},     64'(busy),     64'd0);
  endtask

  task automatic run_tur(input string nm);
    int s0, b0, w0, r0;
    s0 = stat_cnt; b0 = busy_cnt; w0 = wr_cnt; r0 = rd_cnt;
    push_ev(K_STAT, 8'h00);
    send(cdb_op(8'h00));
    wait_stat(s0, 20);
    check({nm, "_latency"}, 64'(stat_cyc - cmd_cyc), 64'd3);
    repeat (3) @(negedge clk);
    #2;
    check({nm, "_busy_cycles"}, 64'(busy_cnt - b0), 64'd3);
    check({nm, "_no_cd_wr"},    64'(wr_cnt - w0),   64'd0);
    check({nm, "_no_src_rd"},   64'(rd_cnt - r0),   64'd0);
  endtask

  task automatic run_read(input string nm, input logic [31:0] lba, input logic [15:0] len,
                          input int lmode, input bit poke, input int budget);
    int s0, w0, e0, r0, nb;
    s0 = stat_cnt; w0 = wr_cnt; e0 = end_cnt; r0 = rd_cnt;
    nb = int'(len) * SECT;
    src_start = lba;
    lat_mode  = lmode;
    push_bytes(lba, nb);
    if (nb > 0) push_ev(K_END, 8'h00);
    push_ev(K_STAT, 8'h00);
    send(cdb_read(lba, len));
    if (poke) begin
      repeat (300) @(negedge clk);
      send(cdb_op(8'h00));      // illegal while BUSY: must be ignored
    end
    wait_stat(s0, budget);
    repeat (3) @(negedge clk);
    #2;
    check({nm, "_cd_wr_count"},  64'(wr_cnt - w0),  64'(nb));
    check({nm, "_src_rd_count"}, 64'(rd_cnt - r0),  64'(nb));
    check({nm, "_cd_end_count"}, 64'(end_cnt - e0), (nb > 0) ? 64'd1 : 64'd0);
    check({nm, "_queue_empty"},  64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s0, w0, r0, n;
    rst       = 1'b1;
    command   = '0;
    comm_send = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: TEST UNIT READY
    run_tur("tur");

    // 2: READ(10) one block at LBA 0x10, fixed source latency
    run_read("read1", 32'h0000_0010, 16'd1, 0, 1'b0, 20000);
    check("read1_status", 64'(status), 64'h00);

    // 3: READ(10) two blocks across the 32-bit LBA wrap
    run_read("readwrap", 32'hFFFF_FFFF, 16'd2, 0, 1'b0, 40000);

    // 4: zero-length READ(10), then an unsupported opcode
    run_read("read0", 32'h0000_1234, 16'd0, 0, 1'b0, 50);
    s0 = stat_cnt;
    push_ev(K_STAT, 8'h02);
    send(cdb_op(8'h12));
    wait_stat(s0, 20);
    repeat (5) @(negedge clk);
    check("inquiry_status_hold", 64'(status), 64'h02);

    // 5: reset after 100 bytes of a READ, late source answer must be dropped
    w0 = wr_cnt;
    src_start = 32'h0000_0100;
    lat_mode  = 2;
    push_bytes(32'h0000_0100, 100);
    send(cdb_read(32'h0000_0100, 16'd1));
    n = 0;
    while (wr_cnt - w0 < 100 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("rst_mid_wr_count", 64'(wr_cnt - w0), 64'd100);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    repeat (12) @(negedge clk);
    #2;
    check("rst_after_no_cd_wr",  64'(wr_cnt - w0),  64'd0);
    check("rst_after_no_src_rd", 64'(rd_cnt - r0),  64'd0);
    check("rst_after_queue",     64'(exp_q.size()), 64'd0);
    check("rst_after_busy",      64'(busy),         64'd0);
    run_tur("tur_after_rst");

    // 6: random source latency plus an illegal COMM_SEND mid-transfer
    run_read("read_rand", 32'h0000_0010, 16'd1, 1, 1'b1, 60000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
